// File: rtl/cpu_debug_ocimem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ocimem_arbiter_pkg
//  Description : Shared types and jdo field positions for the OCI debug RAM
//                arbiter (FSM states, requester ids, pulse counting helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_debug_ocimem_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT_JTAG = 2'd1,
        ST_GNT_LOC  = 2'd2,
        ST_RD_WAIT  = 2'd3
    } ocimem_state_t;

    // Requester identity, also used for the round-robin history
    typedef enum logic {
        REQ_JTAG = 1'b0,
        REQ_LOC  = 1'b1
    } ocimem_req_t;

    // jdo layout: address field starts at bit 17, write data is jdo[34:3]
    localparam int C_JDO_W        = 38;
    localparam int C_JDO_ADDR_LSB = 17;
    localparam int C_JDO_DATA_MSB = 34;
    localparam int C_JDO_DATA_LSB = 3;

    // Number of JTAG action pulses asserted in one cycle (0..3)
    function automatic logic [1:0] pulse_count(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_debug_ocimem_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ocimem_rr_arb
//  Description : Two-way round-robin arbiter between the JTAG pending op and
//                the local requester. A lone requester is always granted;
//                under contention the side not granted last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_debug_ocimem_rr_arb
    import cpu_debug_ocimem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_jtag,
    input  logic req_loc,
    input  logic advance,
    output logic gnt_jtag,
    output logic gnt_loc
);

    ocimem_req_t r_last_gnt;

    assign gnt_jtag = req_jtag & (~req_loc  | (r_last_gnt == REQ_LOC));
    assign gnt_loc  = req_loc  & (~req_jtag | (r_last_gnt == REQ_JTAG));

    // Remember who was granted whenever an access is actually issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= REQ_LOC;
        end else if (advance && (gnt_jtag || gnt_loc)) begin
            r_last_gnt <= gnt_jtag ? REQ_JTAG : REQ_LOC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_debug_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ocimem_arbiter
//  Description : Sequences the single-port OCI debug RAM between the JTAG
//                debug host (action pulses + jdo) and a local requester.
//                Owns the auto-incrementing debug address register and the
//                MonDReg / monitor_ready / monitor_error handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_debug_ocimem_arbiter
    import cpu_debug_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [C_JDO_W-1:0] jdo,
    input  logic               take_action_ocimem_a,
    input  logic               take_action_ocimem_b,
    input  logic               take_no_action_ocimem_a,
    output logic [DATA_W-1:0]  MonDReg,
    output logic               monitor_ready,
    output logic               monitor_error,
    input  logic               loc_req,
    input  logic               loc_we,
    input  logic [ADDR_W-1:0]  loc_addr,
    input  logic [DATA_W-1:0]  loc_wdata,
    output logic               loc_gnt,
    output logic               loc_rvalid,
    output logic [DATA_W-1:0]  loc_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    // JTAG side state
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend_vld;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;

    // Sequencer state
    ocimem_state_t     r_state;
    ocimem_req_t       r_cur_src;
    logic              r_cur_we;

    logic              w_multi;
    logic              w_jtag_op;
    logic              w_pend_clr;
    logic              w_jtag_done;
    logic              w_gnt_jtag;
    logic              w_gnt_loc;
    logic              w_advance;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic [DATA_W-1:0] w_jdo_data;
    logic              w_unused_jdo;

    assign w_jdo_addr   = jdo[C_JDO_ADDR_LSB +: ADDR_W];
    assign w_jdo_data   = jdo[C_JDO_DATA_MSB:C_JDO_DATA_LSB];
    assign w_unused_jdo = ^{jdo[C_JDO_W-1:C_JDO_DATA_MSB+1], jdo[C_JDO_DATA_LSB-1:0]};

    // More than one pulse in a cycle is illegal; ocimem_a still takes effect
    assign w_multi    = (pulse_count(take_action_ocimem_a, take_action_ocimem_b,
                                     take_no_action_ocimem_a) > 2'd1);
    assign w_jtag_op  = ~w_multi & (take_action_ocimem_b | take_no_action_ocimem_a);

    // The pending slot is consumed when its access is on the RAM bus
    assign w_pend_clr  = (r_state == ST_GNT_JTAG);
    assign w_jtag_done = ((r_state == ST_GNT_JTAG) && r_cur_we) ||
                         ((r_state == ST_RD_WAIT)  && (r_cur_src == REQ_JTAG));
    assign w_advance   = (r_state == ST_IDLE);

    cpu_debug_ocimem_rr_arb u_rr_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_jtag (r_pend_vld),
        .req_loc  (loc_req),
        .advance  (w_advance),
        .gnt_jtag (w_gnt_jtag),
        .gnt_loc  (w_gnt_loc)
    );

    // JTAG capture: address register, 1-deep pending op, ready/error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_pend_vld    <= 1'b0;
            r_pend_we     <= 1'b0;
            r_pend_addr   <= '0;
            r_pend_data   <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end
            if (w_jtag_done) begin
                monitor_ready <= 1'b1;
            end
            if (take_action_ocimem_a) begin
                // Address load clears the error unless it collided with another pulse
                r_addr        <= w_jdo_addr;
                monitor_error <= w_multi;
            end else if (w_multi) begin
                monitor_error <= 1'b1;
            end else if (w_jtag_op) begin
                if (r_pend_vld) begin
                    // Overrun: keep the queued op, drop the new one
                    monitor_error <= 1'b1;
                end else begin
                    r_pend_vld    <= 1'b1;
                    r_pend_we     <= take_action_ocimem_b;
                    r_pend_addr   <= r_addr;
                    r_pend_data   <= w_jdo_data;
                    r_addr        <= r_addr + 1'b1;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end

    // Access sequencer: issue from IDLE, drive RAM in GNT_*, collect read data in RD_WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cur_src  <= REQ_LOC;
            r_cur_we   <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            loc_rdata  <= '0;
            MonDReg    <= '0;
        end else begin
            ram_we     <= 1'b0;
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_jtag) begin
                        r_state   <= ST_GNT_JTAG;
                        r_cur_src <= REQ_JTAG;
                        r_cur_we  <= r_pend_we;
                        ram_addr  <= r_pend_addr;
                        ram_we    <= r_pend_we;
                        ram_wdata <= r_pend_data;
                    end else if (w_gnt_loc) begin
                        r_state   <= ST_GNT_LOC;
                        r_cur_src <= REQ_LOC;
                        r_cur_we  <= loc_we;
                        ram_addr  <= loc_addr;
                        ram_we    <= loc_we;
                        ram_wdata <= loc_wdata;
                        loc_gnt   <= 1'b1;
                    end
                end
                ST_GNT_JTAG, ST_GNT_LOC: begin
                    r_state <= r_cur_we ? ST_IDLE : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_cur_src == REQ_JTAG) begin
                        MonDReg <= ram_rdata;
                    end else begin
                        loc_rdata  <= ram_rdata;
                        loc_rvalid <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_debug_ocimem_arbiter
//  Description : Directed bench for the OCI debug RAM arbiter with a simple
//                registered-read RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        loc_req;
    logic        loc_we;
    logic [7:0]  loc_addr;
    logic [31:0] loc_wdata;
    logic        loc_gnt;
    logic        loc_rvalid;
    logic [31:0] loc_rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int wc;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    cpu_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .loc_req                 (loc_req),
        .loc_we                  (loc_we),
        .loc_addr                (loc_addr),
        .loc_wdata               (loc_wdata),
        .loc_gnt                 (loc_gnt),
        .loc_rvalid              (loc_rvalid),
        .loc_rdata               (loc_rdata),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    // Single-port RAM, one-cycle registered read, plus a write counter
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        return 38'(a) << 17;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic jtag_load(input logic [7:0] a);
        jdo = jdo_addr(a);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    // Pulse in N; RAM write seen in N+2; monitor_ready back in N+3
    task automatic jtag_write(input logic [31:0] d, input logic [7:0] exp_addr);
        jdo = jdo_data(d);
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("wr_ready_n1", monitor_ready, 1'b0);
        step();
        @(negedge clk);
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_ram_addr", ram_addr, exp_addr);
        chk("wr_ram_wdata", ram_wdata, d);
        chk("wr_ready_n2", monitor_ready, 1'b0);
        step();
        @(negedge clk);
        chk("wr_ready_n3", monitor_ready, 1'b1);
        chk("wr_ram_we_off", ram_we, 1'b0);
    endtask

    // Pulse in N; RAM read addressed in N+2; MonDReg and ready in N+4
    task automatic jtag_read(input logic [7:0] exp_addr, input logic [31:0] exp_data);
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        chk("rd_ready_n1", monitor_ready, 1'b0);
        step();
        @(negedge clk);
        chk("rd_ram_addr", ram_addr, exp_addr);
        chk("rd_ram_we", ram_we, 1'b0);
        step();
        @(negedge clk);
        chk("rd_ready_n3", monitor_ready, 1'b0);
        step();
        @(negedge clk);
        chk("rd_mondreg", MonDReg, exp_data);
        chk("rd_ready_n4", monitor_ready, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        loc_req = 1'b0;
        loc_we = 1'b0;
        loc_addr = '0;
        loc_wdata = '0;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", monitor_ready, 1'b1);
        chk("rst_error", monitor_error, 1'b0);
        chk("rst_loc_gnt", loc_gnt, 1'b0);
        chk("rst_loc_rvalid", loc_rvalid, 1'b0);
        chk("rst_loc_rdata", loc_rdata, 32'h0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 8'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        step();
        reset_n = 1'b1;
        step();

        // JTAG write at 0x10, then read it back; address register ends at 0x11
        jtag_load(8'h10);
        jtag_write(32'hDEADBEEF, 8'h10);
        jtag_load(8'h10);
        jtag_read(8'h10, 32'hDEADBEEF);
        jtag_write(32'h11111111, 8'h11);

        // Address wrap 0xFF -> 0x00
        jtag_load(8'hFF);
        jtag_write(32'hAAAA0001, 8'hFF);
        jtag_write(32'hAAAA0002, 8'h00);
        jtag_load(8'h00);
        jtag_read(8'h00, 32'hAAAA0002);

        // Illegal: ocimem_a and ocimem_b together -> load only, error set
        jdo = jdo_addr(8'h40);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        wc = wr_cnt;
        step();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("multi_error", monitor_error, 1'b1);
        chk("multi_ready", monitor_ready, 1'b1);
        step();
        step();
        @(negedge clk);
        chk("multi_no_we", ram_we, 1'b0);
        chk("multi_no_write", wr_cnt - wc, 0);
        jtag_write(32'h40404040, 8'h40);
        chk("err_sticky", monitor_error, 1'b1);
        jtag_load(8'h30);
        @(negedge clk);
        chk("err_cleared", monitor_error, 1'b0);

        // Local write then local read at 0x20
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h20; loc_wdata = 32'hCAFEF00D;
        step();
        loc_req = 1'b0;
        @(negedge clk);
        chk("lw_gnt", loc_gnt, 1'b1);
        chk("lw_ram_we", ram_we, 1'b1);
        chk("lw_ram_addr", ram_addr, 8'h20);
        chk("lw_ram_wdata", ram_wdata, 32'hCAFEF00D);
        step();
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h20;
        step();
        loc_req = 1'b0;
        @(negedge clk);
        chk("lr_gnt", loc_gnt, 1'b1);
        chk("lr_ram_we", ram_we, 1'b0);
        step();
        @(negedge clk);
        chk("lr_rvalid_early", loc_rvalid, 1'b0);
        chk("lr_gnt_off", loc_gnt, 1'b0);

        // Contention: JTAG write 0x30 and local read 0x20 meet in IDLE, last grant was LOC
        jdo = jdo_data(32'h5A5A5A5A);
        take_action_ocimem_b = 1'b1;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h20;
        step();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("lr_rvalid", loc_rvalid, 1'b1);
        chk("lr_rdata", loc_rdata, 32'hCAFEF00D);
        step();
        @(negedge clk);
        chk("ct_jtag_we", ram_we, 1'b1);
        chk("ct_jtag_addr", ram_addr, 8'h30);
        chk("ct_jtag_wdata", ram_wdata, 32'h5A5A5A5A);
        chk("ct_no_loc_gnt", loc_gnt, 1'b0);
        step();
        @(negedge clk);
        chk("ct_jtag_ready", monitor_ready, 1'b1);
        chk("ct_loc_wait", loc_gnt, 1'b0);
        step();
        loc_req = 1'b0;
        @(negedge clk);
        chk("ct_loc_gnt", loc_gnt, 1'b1);
        chk("ct_loc_addr", ram_addr, 8'h20);
        step();
        @(negedge clk);
        chk("ct_rvalid_early", loc_rvalid, 1'b0);
        step();
        @(negedge clk);
        chk("ct_rvalid", loc_rvalid, 1'b1);
        chk("ct_rdata", loc_rdata, 32'hCAFEF00D);
        step();

        // Overrun: second ocimem_b while the first waits behind a local read
        wc = wr_cnt;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h30;
        jdo = jdo_data(32'h01234567);
        take_action_ocimem_b = 1'b1;
        step();
        loc_req = 1'b0;
        jdo = jdo_data(32'h89ABCDEF);
        @(negedge clk);
        chk("ov_loc_gnt", loc_gnt, 1'b1);
        step();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("ov_error", monitor_error, 1'b1);
        step();
        @(negedge clk);
        chk("ov_loc_rvalid", loc_rvalid, 1'b1);
        chk("ov_loc_rdata", loc_rdata, 32'h5A5A5A5A);
        step();
        @(negedge clk);
        chk("ov_we", ram_we, 1'b1);
        chk("ov_addr", ram_addr, 8'h31);
        chk("ov_wdata", ram_wdata, 32'h01234567);
        step();
        @(negedge clk);
        chk("ov_ready", monitor_ready, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk("ov_one_write", wr_cnt - wc, 1);
        chk("ov_error_held", monitor_error, 1'b1);
        jtag_load(8'h10);
        @(negedge clk);
        chk("ov_error_clr", monitor_error, 1'b0);

        // Asynchronous reset while a JTAG read sits in GNT_JTAG
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        step();
        @(negedge clk);
        chk("ar_in_gnt", ram_addr, 8'h10);
        reset_n = 1'b0;
        #1;
        chk("ar_mondreg", MonDReg, 32'h0);
        chk("ar_ready", monitor_ready, 1'b1);
        chk("ar_ram_addr", ram_addr, 8'h0);
        step();
        step();
        reset_n = 1'b1;
        wc = wr_cnt;
        repeat (5) step();
        @(negedge clk);
        chk("ar_no_stale_mond", MonDReg, 32'h0);
        chk("ar_no_stale_ready", monitor_ready, 1'b1);
        chk("ar_no_write", wr_cnt - wc, 0);
        chk("ar_no_rvalid", loc_rvalid, 1'b0);
        jtag_load(8'h10);
        jtag_read(8'h10, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_debug_ocimem_arbiter.md
Name: cpu_debug_ocimem_arbiter

Overview:
Sequences the CPU debug-module on-chip memory (OCI debug RAM, single port, 1-cycle registered read) between two requesters: the JTAG debug host (sysclk-side take_action_ocimem_* pulses plus jdo) and a local fabric requester (board-test master). It owns the auto-incrementing debug address register, returns readback in MonDReg, and drives monitor_ready/monitor_error back to the JTAG TCK-side logic. It sits on clk beside the jtag_debug_module wrapper.

Parameters:
ADDR_W, 8, debug RAM word-address width; the address field is jdo[17+ADDR_W-1:17].
DATA_W, 32, data width; fixed at 32 because write data is jdo[34:3].

Ports:
clk  in  1  system clock; one clock domain.
reset_n  in  1  asynchronous, active-low reset.
jdo  in  38  JTAG data out; the address and write-data fields are defined above.
take_action_ocimem_a  in  1  1-cycle pulse: load the address register from jdo.
take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at the address register, then increment it.
take_no_action_ocimem_a  in  1  1-cycle pulse: read at the address register, then increment it.
MonDReg  out  32  last JTAG readback data.
monitor_ready  out  1  JTAG op complete / idle.
monitor_error  out  1  sticky overrun or illegal-pulse flag.
loc_req  in  1  local request; held until granted.
loc_we  in  1  local write (1) or read (0).
loc_addr  in  ADDR_W  local word address.
loc_wdata  in  32  local write data.
loc_gnt  out  1  1-cycle grant; the local access is on the ram_* outputs in this cycle.
loc_rvalid  out  1  local read data valid, 2 cycles after a read grant.
loc_rdata  out  32  local read data.
ram_addr  out  ADDR_W  debug RAM address.
ram_we  out  1  debug RAM write enable.
ram_wdata  out  32  debug RAM write data.
ram_rdata  in  32  debug RAM read data, valid the cycle after ram_addr.

Behaviour:
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, loc_gnt=0, loc_rvalid=0, loc_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, address register=0, pending=0, last_gnt=LOC. FSM goes to IDLE.
- Reset mid-operation: any pending or in-flight op is discarded and no completion is signalled.
- Capture:
  - A JTAG read/write pulse loads the 1-deep pending register {we, addr=address register, data}.
  - The address register increments in the same edge; it wraps 2^ADDR_W-1 -> 0.
  - monitor_ready is cleared on the same edge.
  - take_action_ocimem_a loads the address register and clears monitor_error. It does not affect an op already pending.
- Overrun: a JTAG read/write pulse while pending=1 is dropped and sets monitor_error. The pending op is unchanged.
- Illegal pulses:
  - More than one of the three pulses in the same cycle: take_action_ocimem_a wins, the others are ignored, and monitor_error is set.
  - This holds even if a subset is legal.
- FSM IDLE:
  - If exactly one requester is pending, issue its access.
  - If both are pending, grant the one not equal to last_gnt (round-robin), then update last_gnt.
  - Issue means ram_addr/ram_we/ram_wdata are registered and valid in the next cycle (the GNT_* cycle).
- FSM GNT_JTAG: RAM access is active and pending clears.
  - Write: monitor_ready=1 on the next edge, return to IDLE.
  - Read: go to RD_WAIT.
- FSM GNT_LOC: loc_gnt=1 for exactly this cycle with the access on ram_*. Write goes to IDLE; read goes to RD_WAIT.
- FSM RD_WAIT: ram_rdata is sampled and the FSM returns to IDLE; no new access is issued in this cycle.
  - JTAG read: MonDReg<=ram_rdata and monitor_ready<=1 on this edge.
  - Local read: loc_rdata is registered and loc_rvalid is pulsed for one cycle.
- ram_we is high only in GNT_* write cycles. Writes allow back-to-back issue, one access per 2 cycles (IDLE, GNT). Reads use 3 cycles.
- JTAG latency from an idle machine:
  - Pulse in cycle N: capture, then IDLE N+1, GNT_JTAG N+2.
  - Write: monitor_ready=1 from N+3.
  - Read: RD_WAIT N+3, MonDReg and monitor_ready=1 from N+4.
- Local latency from IDLE with loc_req: loc_gnt at N+1; loc_rvalid at N+3.
- A local request with no competitor is never starved; JTAG waits at most one local access.

Decomposition:
- Shared package: FSM state enum {IDLE, GNT_JTAG, GNT_LOC, RD_WAIT}, jdo field position constants (address LSB 17, data 34:3), requester id enum {JTAG, LOC}.
- One sub-module: cpu_debug_ocimem_rr_arb (2-way round-robin with last_gnt state).

Test Plan:
- JTAG write: ocimem_a with addr 0x10, then ocimem_b data 0xDEADBEEF -> ram_we at addr 0x10 with 0xDEADBEEF; address register = 0x11; monitor_ready=1 at N+3.
- JTAG read: ocimem_a addr 0x10, then take_no_action_ocimem_a with RAM model returning 0xDEADBEEF -> MonDReg=0xDEADBEEF at N+4; address register = 0x11.
- Wrap: addr 0xFF, two writes -> accesses at 0xFF then 0x00.
- Contention: loc_req read addr 0x20 held, with a JTAG write pulse in the same cycle -> grants alternate (JTAG first since last_gnt=LOC at reset), then local; loc_rvalid 2 cycles after loc_gnt.
- Overrun: second ocimem_b while the first is pending behind a local read -> only the first write occurs; monitor_error=1; cleared by the next ocimem_a.
- Async reset: assert reset_n=0 in GNT_JTAG during a read -> MonDReg=0, monitor_ready=1, no stale completion after release.
